// File: rtl/iob_eth_bd_pkg.sv
// iob_eth_bd_pkg: buffer-descriptor field positions, scheduler states and DMA direction codes.
package iob_eth_bd_pkg;
  localparam int BD_LEN_LSB = 16;
  localparam int BD_READY = 15;
  localparam int BD_IRQ = 14;
  localparam int BD_WRAP = 13;
  localparam int BD_STAT_W = 8;
  localparam logic DIR_TX = 1'b0;
  localparam logic DIR_RX = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CTRL,
    S_RD_PTR,
    S_ISSUE,
    S_WAIT_DONE,
    S_WR_BACK
  } state_t;
endpackage

// File: rtl/iob_eth_bd_ring_ptr.sv
// iob_eth_bd_ring_ptr: descriptor ring pointer kept as an offset from the ring start.
// Storing the offset lets reset clear it to 0 even though the ring start is a run-time input.
module iob_eth_bd_ring_ptr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold_i,
  input  logic         adv_i,
  input  logic         wrap_i,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] size_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] off_q, off_d;
  always_comb off_d = hold_i ? '0 : !adv_i ? off_q :
                      (wrap_i || off_q == size_i - W'(1)) ? '0 : off_q + W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) off_q <= '0;
    else off_q <= off_d;
  assign ptr_o = start_i + off_q;
endmodule

// File: rtl/iob_eth_bd_sched.sv
// iob_eth_bd_sched: round-robin TX/RX buffer-descriptor scheduler feeding a DMA engine.
// Define IOB_ETH_BD_IRQ_EN to enable the per-descriptor completion interrupts.
module iob_eth_bd_sched
  import iob_eth_bd_pkg::*;
#(
  parameter int BD_NUM_LOG2 = 7,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en_i,
  input  logic                   rx_en_i,
  input  logic [BD_NUM_LOG2:0]   tx_bd_num_i,
  output logic                   bd_en_o,
  output logic [BD_NUM_LOG2:0]   bd_addr_o,
  output logic                   bd_wen_o,
  output logic [31:0]            bd_o,
  input  logic [31:0]            bd_i,
  output logic                   job_valid_o,
  input  logic                   job_ready_i,
  output logic                   job_dir_o,
  output logic [LEN_W-1:0]       job_len_o,
  output logic [31:0]            job_ptr_o,
  input  logic                   done_i,
  input  logic [LEN_W-1:0]       done_len_i,
  input  logic [BD_STAT_W-1:0]   done_status_i,
  output logic                   busy_o,
  output logic                   tx_irq_o,
  output logic                   rx_irq_o,
  input  logic [1:0]             irq_clr_i
);
  localparam int W = BD_NUM_LOG2 + 1;
  localparam logic [W-1:0] BD_CNT = W'(1) << BD_NUM_LOG2;
  state_t state_q, state_d;
  logic dir_q, dir_d, last_q, last_d, ph_q, ph_d;
  logic [31:0] ctrl_q, ctrl_d, ptr_q, ptr_d;
  logic [W-1:0] tx_ptr, rx_ptr, cur;
  logic tx_ok, rx_ok, active, wb;
  assign tx_ok = tx_en_i && tx_bd_num_i != '0;
  assign rx_ok = rx_en_i && tx_bd_num_i < BD_CNT;
  assign active = state_q != S_IDLE;
  assign wb = state_q == S_WR_BACK;
  assign cur = dir_q ? rx_ptr : tx_ptr;
  // A ring whose job is still in flight keeps its pointer so the write-back lands correctly.
  iob_eth_bd_ring_ptr #(.W(W)) u_tx_ptr (
    .clk(clk), .rst(rst),
    .hold_i(!tx_en_i && !(active && dir_q == DIR_TX)),
    .adv_i(wb && dir_q == DIR_TX), .wrap_i(ctrl_q[BD_WRAP]),
    .start_i('0), .size_i(tx_bd_num_i), .ptr_o(tx_ptr)
  );
  iob_eth_bd_ring_ptr #(.W(W)) u_rx_ptr (
    .clk(clk), .rst(rst),
    .hold_i(!rx_en_i && !(active && dir_q == DIR_RX)),
    .adv_i(wb && dir_q == DIR_RX), .wrap_i(ctrl_q[BD_WRAP]),
    .start_i(tx_bd_num_i), .size_i(BD_CNT - tx_bd_num_i), .ptr_o(rx_ptr)
  );
  // Read states spend one cycle issuing the access (ph_q=0) and one consuming bd_i (ph_q=1).
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    last_d = last_q;
    ph_d = 1'b0;
    ctrl_d = ctrl_q;
    ptr_d = ptr_q;
    case (state_q)
      S_IDLE: if (tx_ok || rx_ok) begin
        dir_d = (tx_ok && rx_ok) ? ~last_q : rx_ok;
        last_d = dir_d;
        state_d = S_RD_CTRL;
      end
      S_RD_CTRL: begin
        ph_d = !ph_q;
        if (ph_q) begin
          ctrl_d = bd_i;
          state_d = bd_i[BD_READY] ? S_RD_PTR : S_IDLE;
        end
      end
      S_RD_PTR: begin
        ph_d = !ph_q;
        if (ph_q) begin
          ptr_d = bd_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = job_ready_i ? S_WAIT_DONE : S_ISSUE;
      S_WAIT_DONE: if (done_i) begin
        ctrl_d = {dir_q == DIR_RX ? 16'(done_len_i) : ctrl_q[31:BD_LEN_LSB], 1'b0,
                  ctrl_q[BD_IRQ:BD_STAT_W], done_status_i};
        state_d = S_WR_BACK;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      dir_q <= DIR_TX;
      last_q <= DIR_RX;
      ph_q <= 1'b0;
      ctrl_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      last_q <= last_d;
      ph_q <= ph_d;
      ctrl_q <= ctrl_d;
      ptr_q <= ptr_d;
    end
  assign bd_en_o = ((state_q == S_RD_CTRL || state_q == S_RD_PTR) && !ph_q) || wb;
  assign bd_addr_o = bd_en_o ? W'({cur, state_q == S_RD_PTR}) : '0;
  assign bd_wen_o = wb;
  assign bd_o = wb ? ctrl_q : '0;
  assign job_valid_o = state_q == S_ISSUE;
  assign job_dir_o = job_valid_o && dir_q;
  assign job_len_o = job_valid_o ? LEN_W'(ctrl_q[31:BD_LEN_LSB]) : '0;
  assign job_ptr_o = job_valid_o ? ptr_q : '0;
  assign busy_o = state_q == S_ISSUE || state_q == S_WAIT_DONE || wb;
`ifdef IOB_ETH_BD_IRQ_EN
  logic tx_irq_q, tx_irq_d, rx_irq_q, rx_irq_d, irq_set;
  assign irq_set = wb && ctrl_q[BD_IRQ];
  always_comb begin
    tx_irq_d = (irq_set && dir_q == DIR_TX) || (tx_irq_q && !irq_clr_i[0]);
    rx_irq_d = (irq_set && dir_q == DIR_RX) || (rx_irq_q && !irq_clr_i[1]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_irq_q <= 1'b0;
      rx_irq_q <= 1'b0;
    end else begin
      tx_irq_q <= tx_irq_d;
      rx_irq_q <= rx_irq_d;
    end
  assign tx_irq_o = tx_irq_q;
  assign rx_irq_o = rx_irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^irq_clr_i;
  assign tx_irq_o = 1'b0;
  assign rx_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_iob_eth_bd_sched.sv
// tb_iob_eth_bd_sched: scoreboard bench for iob_eth_bd_sched with a behavioural BD RAM and DMA responder.
// Interrupt checks follow IOB_ETH_BD_IRQ_EN.
module tb_iob_eth_bd_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic tx_en_i = 1'b0, rx_en_i = 1'b0;
  logic [7:0] tx_bd_num_i = 8'd4;
  logic bd_en_o, bd_wen_o;
  logic [7:0] bd_addr_o;
  logic [31:0] bd_o, bd_i;
  logic job_valid_o, job_ready_i = 1'b0, job_dir_o;
  logic [15:0] job_len_o;
  logic [31:0] job_ptr_o;
  logic done_i = 1'b0;
  logic [15:0] done_len_i = '0;
  logic [7:0] done_status_i = '0;
  logic busy_o, tx_irq_o, rx_irq_o;
  logic [1:0] irq_clr_i = '0;
  logic [31:0] mem [0:255];
  logic tb_we = 1'b0, mem_clr = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [31:0] tb_data = '0;
  logic [48:0] exp_job [$];
  logic [39:0] exp_wr [$];
  int checks = 0, errors = 0;
  wire [94:0] outs = {bd_en_o, bd_addr_o, bd_wen_o, bd_o, job_valid_o, job_dir_o,
                      job_len_o, job_ptr_o, busy_o, tx_irq_o, rx_irq_o};

  iob_eth_bd_sched dut (
    .clk(clk), .rst(rst), .tx_en_i(tx_en_i), .rx_en_i(rx_en_i), .tx_bd_num_i(tx_bd_num_i),
    .bd_en_o(bd_en_o), .bd_addr_o(bd_addr_o), .bd_wen_o(bd_wen_o), .bd_o(bd_o), .bd_i(bd_i),
    .job_valid_o(job_valid_o), .job_ready_i(job_ready_i), .job_dir_o(job_dir_o),
    .job_len_o(job_len_o), .job_ptr_o(job_ptr_o), .done_i(done_i), .done_len_i(done_len_i),
    .done_status_i(done_status_i), .busy_o(busy_o), .tx_irq_o(tx_irq_o), .rx_irq_o(rx_irq_o),
    .irq_clr_i(irq_clr_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else begin
      if (tb_we) mem[tb_addr] <= tb_data;
      if (bd_en_o && bd_wen_o) mem[bd_addr_o] <= bd_o;
      if (bd_en_o && !bd_wen_o) bd_i <= mem[bd_addr_o];
    end
  end

  always @(negedge clk) begin
    #2;
    if (job_valid_o && job_ready_i) begin
      checks++;
      if (exp_job.size() == 0) begin
        errors++;
        $display("FAIL job_unexpected: got dir %0d len %h ptr %h", job_dir_o, job_len_o, job_ptr_o);
      end else begin
        automatic logic [48:0] e = exp_job.pop_front();
        if ({job_dir_o, job_len_o, job_ptr_o} !== e) begin
          errors++;
          $display("FAIL job: got dir %0d len %h ptr %h, expected dir %0d len %h ptr %h",
                   job_dir_o, job_len_o, job_ptr_o, e[48], e[47:32], e[31:0]);
        end
      end
    end
    if (bd_en_o && bd_wen_o) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %h data %h", bd_addr_o, bd_o);
      end else begin
        automatic logic [39:0] e = exp_wr.pop_front();
        if ({bd_addr_o, bd_o} !== e) begin
          errors++;
          $display("FAIL writeback: got addr %h data %h, expected addr %h data %h",
                   bd_addr_o, bd_o, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic accept();
    int n = 0;
    while (!job_valid_o && n < 300) begin @(negedge clk); n++; end
    if (!job_valid_o) begin
      checks++; errors++;
      $display("FAIL job_timeout: got no job_valid_o after %0d cycles, expected a job", n);
    end else begin
      job_ready_i = 1'b1;
      @(negedge clk);
      job_ready_i = 1'b0;
    end
  endtask

  task automatic complete(input logic [15:0] dl, input logic [7:0] st, input logic [1:0] clr);
    repeat (2) @(negedge clk);
    done_i = 1'b1; done_len_i = dl; done_status_i = st;
    @(negedge clk);
    done_i = 1'b0;
    irq_clr_i = clr;
    @(negedge clk);
    irq_clr_i = '0;
  endtask

  initial begin
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'(outs), 128'd0);
    mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    done_i = 1'b1; done_status_i = 8'hEE;
    @(negedge clk);
    done_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_stray_done", 128'(outs), 128'd0);

    // TX job on BD0
    poke(8'd0, 32'h0040_8000);
    poke(8'd1, 32'h0000_1000);
    exp_job.push_back({1'b0, 16'd64, 32'h1000});
    exp_wr.push_back({8'd0, 32'h0040_0001});
    tx_en_i = 1'b1;
    accept();
    chk("busy_wait_done", 128'(busy_o), 128'd1);
    complete(16'd0, 8'h01, 2'b00);
    chk("tx_ptr_after_bd0", 128'(dut.tx_ptr), 128'd1);
    chk("mem0_after_tx", 128'(mem[0]), 128'h0040_0001);

    // wrap bit on BD1
    poke(8'd2, 32'h0020_A000);
    poke(8'd3, 32'h0000_2000);
    exp_job.push_back({1'b0, 16'd32, 32'h2000});
    exp_wr.push_back({8'd2, 32'h0020_2002});
    accept();
    complete(16'd0, 8'h02, 2'b00);
    chk("tx_ptr_wrap", 128'(dut.tx_ptr), 128'd0);
    tx_en_i = 1'b0;
    repeat (8) @(negedge clk);

    // RX job on BD4
    chk("rx_ptr_start", 128'(dut.rx_ptr), 128'd4);
    poke(8'd8, 32'h0000_8000);
    poke(8'd9, 32'h0000_3000);
    exp_job.push_back({1'b1, 16'd0, 32'h3000});
    exp_wr.push_back({8'd8, 32'h003C_0005});
    rx_en_i = 1'b1;
    accept();
    complete(16'd60, 8'h05, 2'b00);
    chk("rx_ptr_after_bd4", 128'(dut.rx_ptr), 128'd5);
    chk("mem8_after_rx", 128'(mem[8]), 128'h003C_0005);
    rx_en_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("rx_ptr_hold", 128'(dut.rx_ptr), 128'd4);
    chk("tx_ptr_hold", 128'(dut.tx_ptr), 128'd0);

    // fairness: three READY descriptors per ring
    for (int i = 0; i < 3; i++) begin
      poke(8'(2 * i), 32'h0000_8000 | ((32'h10 + i) << 16));
      poke(8'(2 * i + 1), 32'h100 + i);
      poke(8'(8 + 2 * i), 32'h0000_8000 | ((32'h20 + i) << 16));
      poke(8'(9 + 2 * i), 32'h200 + i);
    end
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        exp_job.push_back({1'b0, 16'(16'h10 + k / 2), 32'h100 + k / 2});
        exp_wr.push_back({8'(k), 16'(16'h10 + k / 2), 8'h00, 8'(8'h10 + k)});
      end else begin
        exp_job.push_back({1'b1, 16'(16'h20 + k / 2), 32'h200 + k / 2});
        exp_wr.push_back({8'(8 + 2 * (k / 2)), 16'(16'h40 + k / 2), 8'h00, 8'(8'h10 + k)});
      end
    end
    tx_en_i = 1'b1; rx_en_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      accept();
      complete(16'(16'h40 + k / 2), 8'(8'h10 + k), 2'b00);
    end
    chk("tx_ptr_after_fair", 128'(dut.tx_ptr), 128'd3);
    chk("rx_ptr_after_fair", 128'(dut.rx_ptr), 128'd7);
    tx_en_i = 1'b0; rx_en_i = 1'b0;
    repeat (10) @(negedge clk);

    // reset while waiting for done
    poke(8'd0, 32'h0050_8000);
    poke(8'd1, 32'h0000_4000);
    exp_job.push_back({1'b0, 16'h50, 32'h4000});
    tx_en_i = 1'b1;
    accept();
    chk("busy_before_rst", 128'(busy_o), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("outputs_after_midjob_rst", 128'(outs), 128'd0);
    tx_en_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mem0_untouched_by_rst", 128'(mem[0]), 128'h0050_8000);

    // IRQ descriptor completing while TX clear is asserted
    poke(8'd0, 32'h0010_C000);
    poke(8'd1, 32'h0000_5000);
    exp_job.push_back({1'b0, 16'h10, 32'h5000});
    exp_wr.push_back({8'd0, 32'h0010_4000});
    tx_en_i = 1'b1;
    accept();
    complete(16'd0, 8'h00, 2'b01);
    tx_en_i = 1'b0;
`ifdef IOB_ETH_BD_IRQ_EN
    chk("tx_irq_set_wins", 128'(tx_irq_o), 128'd1);
    chk("rx_irq_idle", 128'(rx_irq_o), 128'd0);
    irq_clr_i = 2'b01;
    @(negedge clk);
    irq_clr_i = 2'b00;
    chk("tx_irq_cleared", 128'(tx_irq_o), 128'd0);
`else
    chk("tx_irq_tied", 128'(tx_irq_o), 128'd0);
    chk("rx_irq_tied", 128'(rx_irq_o), 128'd0);
`endif
    repeat (10) @(negedge clk);
    chk("jobs_left", 128'(exp_job.size()), 128'd0);
    chk("writes_left", 128'(exp_wr.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
